// File: rtl/ysyx_23060236_trap_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_23060236_trap_ctrl_pkg
//  Description : Shared CSR addresses, trap cause codes, request encodings
//                and sequencer state encoding for the trap controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package ysyx_23060236_trap_ctrl_pkg;

    localparam logic [11:0] C_CSR_MSTATUS = 12'h300;
    localparam logic [11:0] C_CSR_MTVEC   = 12'h305;
    localparam logic [11:0] C_CSR_MEPC    = 12'h341;
    localparam logic [11:0] C_CSR_MCAUSE  = 12'h342;

    localparam logic [1:0]  C_REQ_ECALL   = 2'b00;
    localparam logic [1:0]  C_REQ_EBREAK  = 2'b01;
    localparam logic [1:0]  C_REQ_ILLEGAL = 2'b10;
    localparam logic [1:0]  C_REQ_MRET    = 2'b11;

    localparam logic [31:0] C_CAUSE_ECALL   = 32'd11;
    localparam logic [31:0] C_CAUSE_EBREAK  = 32'd3;
    localparam logic [31:0] C_CAUSE_ILLEGAL = 32'd2;
    localparam logic [31:0] C_CAUSE_IRQ     = 32'h8000_0007;

    // mstatus field positions
    localparam int C_MIE_BIT  = 3;
    localparam int C_MPIE_BIT = 7;
    localparam int C_MPP_LO   = 11;
    localparam int C_MPP_HI   = 12;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_EPC_WR   = 3'd1,
        S_CAUSE_WR = 3'd2,
        S_ST_RD    = 3'd3,
        S_ST_WR    = 3'd4,
        S_VEC_RD   = 3'd5,
        S_EPC_RD   = 3'd6
    } state_e;

    // Synchronous exception cause for a request type (mret has no cause)
    function automatic logic [31:0] req_cause(input logic [1:0] req_type);
        logic [31:0] cause;
        case (req_type)
            C_REQ_ECALL:   cause = C_CAUSE_ECALL;
            C_REQ_EBREAK:  cause = C_CAUSE_EBREAK;
            C_REQ_ILLEGAL: cause = C_CAUSE_ILLEGAL;
            default:       cause = 32'd0;
        endcase
        return cause;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_23060236_mstatus_upd.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_23060236_mstatus_upd
//  Description : Combinational mstatus rewrite for trap entry and mret.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060236_mstatus_upd (
    input  logic [31:0] st_in,
    input  logic        is_mret,
    output logic [31:0] st_out
);
    import ysyx_23060236_trap_ctrl_pkg::*;

    // Trap entry stacks MIE into MPIE; mret restores it. MPP is always M-mode.
    always_comb begin
        st_out                     = st_in;
        st_out[C_MPP_HI:C_MPP_LO]  = 2'b11;
        if (is_mret) begin
            st_out[C_MIE_BIT]  = st_in[C_MPIE_BIT];
            st_out[C_MPIE_BIT] = 1'b1;
        end else begin
            st_out[C_MPIE_BIT] = st_in[C_MIE_BIT];
            st_out[C_MIE_BIT]  = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_23060236_trap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_23060236_trap_ctrl
//  Description : Trap sequencer owning the CSR file port. Expands traps,
//                interrupts and mret into CSR read/write sequences, emits one
//                PC redirect per event and passes CSR-instruction writes
//                through while idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060236_trap_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_type,
    input  logic [31:0] req_pc,
    input  logic        irq,
    input  logic [31:0] irq_pc,
    output logic        irq_ack,
    input  logic        inst_csr_valid,
    input  logic [11:0] inst_csr_addr,
    input  logic [31:0] inst_csr_wdata,
    output logic        inst_csr_ready,
    output logic [11:0] csr_addr,
    output logic [31:0] csr_wdata,
    output logic        csr_wen,
    input  logic [31:0] csr_rdata,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy
);
    import ysyx_23060236_trap_ctrl_pkg::*;

    state_e      r_state;
    state_e      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_cause;
    logic [31:0] r_st_q;
    logic [31:0] w_st_new;
    logic        r_is_mret;
    logic        r_mie_shadow;
    logic        w_take_irq;
    logic        w_take_req;
    logic        w_pass_wr;

    ysyx_23060236_mstatus_upd u_mstatus_upd (
        .st_in   (r_st_q),
        .is_mret (r_is_mret),
        .st_out  (w_st_new)
    );

    // State register, event latches, mstatus capture and MIE shadow
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_pc         <= 32'd0;
            r_cause      <= 32'd0;
            r_is_mret    <= 1'b0;
            r_st_q       <= 32'd0;
            r_mie_shadow <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_take_irq) begin
                r_pc      <= irq_pc;
                r_cause   <= C_CAUSE_IRQ;
                r_is_mret <= 1'b0;
            end else if (w_take_req) begin
                r_pc      <= req_pc;
                r_cause   <= req_cause(req_type);
                r_is_mret <= (req_type == C_REQ_MRET);
            end
            if (r_state == S_ST_RD) begin
                r_st_q <= csr_rdata;
            end
            if (r_state == S_ST_WR) begin
                r_mie_shadow <= w_st_new[C_MIE_BIT];
            end else if (w_pass_wr && (inst_csr_addr == C_CSR_MSTATUS)) begin
                r_mie_shadow <= inst_csr_wdata[C_MIE_BIT];
            end
        end
    end

    // Next state, idle arbitration and CSR port drive; everything is
    // forced low while reset is asserted so the port goes quiet at once.
    always_comb begin
        w_next_state   = r_state;
        w_take_irq     = 1'b0;
        w_take_req     = 1'b0;
        w_pass_wr      = 1'b0;
        req_ready      = 1'b0;
        irq_ack        = 1'b0;
        inst_csr_ready = 1'b0;
        csr_addr       = 12'd0;
        csr_wdata      = 32'd0;
        csr_wen        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        if (reset) begin
            case (r_state)
                S_IDLE: begin
                    if (irq && r_mie_shadow) begin
                        w_take_irq   = 1'b1;
                        irq_ack      = 1'b1;
                        w_next_state = S_EPC_WR;
                    end else if (req_valid) begin
                        w_take_req   = 1'b1;
                        req_ready    = 1'b1;
                        w_next_state = (req_type == C_REQ_MRET) ? S_ST_RD : S_EPC_WR;
                    end else if (inst_csr_valid) begin
                        w_pass_wr      = 1'b1;
                        inst_csr_ready = 1'b1;
                        csr_wen        = 1'b1;
                        csr_addr       = inst_csr_addr;
                        csr_wdata      = inst_csr_wdata;
                    end
                end
                S_EPC_WR: begin
                    csr_wen      = 1'b1;
                    csr_addr     = C_CSR_MEPC;
                    csr_wdata    = r_pc;
                    w_next_state = S_CAUSE_WR;
                end
                S_CAUSE_WR: begin
                    csr_wen      = 1'b1;
                    csr_addr     = C_CSR_MCAUSE;
                    csr_wdata    = r_cause;
                    w_next_state = S_ST_RD;
                end
                S_ST_RD: begin
                    csr_addr     = C_CSR_MSTATUS;
                    w_next_state = S_ST_WR;
                end
                S_ST_WR: begin
                    csr_wen      = 1'b1;
                    csr_addr     = C_CSR_MSTATUS;
                    csr_wdata    = w_st_new;
                    w_next_state = r_is_mret ? S_EPC_RD : S_VEC_RD;
                end
                S_VEC_RD: begin
                    csr_addr       = C_CSR_MTVEC;
                    redirect_valid = 1'b1;
                    redirect_pc    = {csr_rdata[31:2], 2'b00};
                    w_next_state   = S_IDLE;
                end
                S_EPC_RD: begin
                    csr_addr       = C_CSR_MEPC;
                    redirect_valid = 1'b1;
                    redirect_pc    = csr_rdata;
                    w_next_state   = S_IDLE;
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

    assign busy = reset && (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060236_trap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ysyx_23060236_trap_ctrl
//  Description : Self-checking bench for the trap sequencer with a CSR file
//                model, an event-expansion reference model, a vector table,
//                directed corner sequences and randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060236_trap_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_type = 2'b00;
    logic [31:0] req_pc = 32'd0;
    logic        irq = 1'b0;
    logic [31:0] irq_pc = 32'd0;
    logic        irq_ack;
    logic        inst_csr_valid = 1'b0;
    logic [11:0] inst_csr_addr = 12'd0;
    logic [31:0] inst_csr_wdata = 32'd0;
    logic        inst_csr_ready;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_wen;
    logic [31:0] csr_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;

    ysyx_23060236_trap_ctrl u_dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_type       (req_type),
        .req_pc         (req_pc),
        .irq            (irq),
        .irq_pc         (irq_pc),
        .irq_ack        (irq_ack),
        .inst_csr_valid (inst_csr_valid),
        .inst_csr_addr  (inst_csr_addr),
        .inst_csr_wdata (inst_csr_wdata),
        .inst_csr_ready (inst_csr_ready),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .csr_wen        (csr_wen),
        .csr_rdata      (csr_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    // CSR file: combinational read, write at the clock edge; preload port
    logic [31:0] csr_mem [0:4095];
    logic        pl_en = 1'b0;
    logic [11:0] pl_addr = 12'd0;
    logic [31:0] pl_data = 32'd0;
    assign csr_rdata = csr_mem[csr_addr];
    always @(posedge clock) begin
        if (pl_en) csr_mem[pl_addr] <= pl_data;
        else if (csr_wen) csr_mem[csr_addr] <= csr_wdata;
    end

    typedef struct {
        logic        rst_n;
        logic        req_valid;
        logic [1:0]  req_type;
        logic [31:0] req_pc;
        logic        irq;
        logic [31:0] irq_pc;
        logic        inst_valid;
        logic [11:0] inst_addr;
        logic [31:0] inst_wdata;
    } in_t;

    // One expected port cycle of an in-flight trap
    typedef struct {
        logic        wen;
        logic [11:0] addr;
        logic [31:0] data;
        logic        rv;
        logic [31:0] rpc;
    } beat_t;

    typedef struct {
        logic        mie;
        logic        irq;
        logic        req;
        logic [1:0]  typ;
        logic        inst;
        logic        e_ack;
        logic        e_rr;
        logic        e_ir;
        logic [31:0] e_cause;
    } vec_t;

    // Reference model state
    logic [31:0] ref_csr [0:4095];
    logic        m_mie = 1'b0;
    beat_t       q[$];

    int n_vec = 0;
    int n_bad = 0;

    logic [11:0] addrs [5] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h340};
    vec_t        tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic in_t idle_in();
        in_t t;
        t.rst_n = 1'b1; t.req_valid = 1'b0; t.req_type = 2'b00; t.req_pc = 32'd0;
        t.irq = 1'b0; t.irq_pc = 32'd0; t.inst_valid = 1'b0; t.inst_addr = 12'd0;
        t.inst_wdata = 32'd0;
        return t;
    endfunction

    function automatic beat_t mk(input logic w, input logic [11:0] a, input logic [31:0] d,
                                 input logic rv, input logic [31:0] rpc);
        beat_t b;
        b.wen = w; b.addr = a; b.data = d; b.rv = rv; b.rpc = rpc;
        return b;
    endfunction

    function automatic logic [31:0] cause_of(input logic [1:0] t);
        case (t)
            2'b00:   return 32'd11;
            2'b01:   return 32'd3;
            default: return 32'd2;
        endcase
    endfunction

    task automatic apply_wr(input logic [11:0] a, input logic [31:0] d);
        ref_csr[a] = d;
        if (a == 12'h300) m_mie = d[3];
    endtask

    // Expand an accepted event into the port cycles it must produce
    task automatic push_trap(input logic [31:0] pc, input logic [31:0] cause, input logic is_mret);
        logic [31:0] st, nst;
        st = ref_csr[12'h300];
        if (is_mret) nst = (st & ~32'h88) | (st[7] ? 32'h8 : 32'h0) | 32'h1880;
        else         nst = (st & ~32'h88) | (st[3] ? 32'h80 : 32'h0) | 32'h1800;
        if (!is_mret) begin
            q.push_back(mk(1'b1, 12'h341, pc, 1'b0, 32'd0));
            q.push_back(mk(1'b1, 12'h342, cause, 1'b0, 32'd0));
        end
        q.push_back(mk(1'b0, 12'h300, 32'd0, 1'b0, 32'd0));
        q.push_back(mk(1'b1, 12'h300, nst, 1'b0, 32'd0));
        if (is_mret) q.push_back(mk(1'b0, 12'h341, 32'd0, 1'b1, ref_csr[12'h341]));
        else         q.push_back(mk(1'b0, 12'h305, 32'd0, 1'b1, ref_csr[12'h305] & ~32'h3));
    endtask

    // Drive one cycle, compare every output with the model, advance the model
    task automatic step(input in_t i);
        beat_t       b;
        logic        e_busy, e_ack, e_rr, e_ir, e_wen, e_rv;
        logic [11:0] e_addr;
        logic [31:0] e_wd, e_rpc;
        @(negedge clock);
        reset = i.rst_n; req_valid = i.req_valid; req_type = i.req_type; req_pc = i.req_pc;
        irq = i.irq; irq_pc = i.irq_pc; inst_csr_valid = i.inst_valid;
        inst_csr_addr = i.inst_addr; inst_csr_wdata = i.inst_wdata;
        #1;
        e_busy = 1'b0; e_ack = 1'b0; e_rr = 1'b0; e_ir = 1'b0; e_wen = 1'b0; e_rv = 1'b0;
        e_addr = 12'd0; e_wd = 32'd0; e_rpc = 32'd0;
        if (i.rst_n) begin
            if (q.size() != 0) begin
                b = q[0];
                e_busy = 1'b1; e_wen = b.wen; e_addr = b.addr; e_wd = b.wen ? b.data : 32'd0;
                e_rv = b.rv; e_rpc = b.rpc;
            end else if (i.irq && m_mie) begin
                e_ack = 1'b1;
            end else if (i.req_valid) begin
                e_rr = 1'b1;
            end else if (i.inst_valid) begin
                e_ir = 1'b1; e_wen = 1'b1; e_addr = i.inst_addr; e_wd = i.inst_wdata;
            end
        end
        chk("busy", 32'(busy), 32'(e_busy));
        chk("irq_ack", 32'(irq_ack), 32'(e_ack));
        chk("req_ready", 32'(req_ready), 32'(e_rr));
        chk("inst_csr_ready", 32'(inst_csr_ready), 32'(e_ir));
        chk("csr_wen", 32'(csr_wen), 32'(e_wen));
        chk("csr_wdata", csr_wdata, e_wd);
        chk("redirect_valid", 32'(redirect_valid), 32'(e_rv));
        if (e_busy || e_wen || !i.rst_n) chk("csr_addr", 32'(csr_addr), 32'(e_addr));
        if (e_rv || !i.rst_n) chk("redirect_pc", redirect_pc, e_rpc);
        if (!i.rst_n) begin
            q.delete();
            m_mie = 1'b0;
        end else if (q.size() != 0) begin
            b = q.pop_front();
            if (b.wen) apply_wr(b.addr, b.data);
        end else if (i.irq && m_mie) begin
            push_trap(i.irq_pc, 32'h8000_0007, 1'b0);
        end else if (i.req_valid) begin
            push_trap(i.req_pc, cause_of(i.req_type), i.req_type == 2'b11);
        end else if (i.inst_valid) begin
            apply_wr(i.inst_addr, i.inst_wdata);
        end
    endtask

    task automatic run_idle(input int n);
        for (int k = 0; k < n; k++) step(idle_in());
    endtask

    task automatic pass_wr(input logic [11:0] a, input logic [31:0] d);
        in_t t;
        t = idle_in(); t.inst_valid = 1'b1; t.inst_addr = a; t.inst_wdata = d;
        step(t);
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        @(negedge clock);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        ref_csr[a] = d;
        @(posedge clock);
        #1 pl_en = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t         t;
        logic [31:0] saved_st;

        tbl[0] = '{1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 32'h8000_0007};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 32'd3};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 32'd2};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0};

        // Reset with CSR preload; activity on every input must stay invisible
        preload(12'h305, 32'h8000_0100);
        preload(12'h300, 32'h0000_1808);
        preload(12'h341, 32'd0);
        preload(12'h342, 32'd0);
        preload(12'h340, 32'd0);
        t = idle_in(); t.rst_n = 1'b0; t.irq = 1'b1; t.req_valid = 1'b1; t.inst_valid = 1'b1;
        t.inst_addr = 12'h341; t.inst_wdata = 32'hDEAD_BEEF;
        step(t);
        step(t);
        run_idle(2);

        // ecall: ordered writes and mtvec redirect at T+5
        t = idle_in(); t.req_valid = 1'b1; t.req_type = 2'b00; t.req_pc = 32'h8000_0040;
        step(t);
        chk("ecall_accept", 32'(req_ready), 32'd1);
        run_idle(1); chk("ecall_mepc", csr_wdata, 32'h8000_0040);
        run_idle(1); chk("ecall_mcause", csr_wdata, 32'd11);
        run_idle(2); chk("ecall_mstatus", csr_wdata, 32'h0000_1880);
        run_idle(1); chk("ecall_redirect", redirect_pc, 32'h8000_0100);
        run_idle(1); chk("ecall_idle", 32'(busy), 32'd0);

        // mret: MIE restored, redirect to mepc at T+3
        t = idle_in(); t.req_valid = 1'b1; t.req_type = 2'b11;
        step(t);
        run_idle(3);
        chk("mret_redirect_v", 32'(redirect_valid), 32'd1);
        chk("mret_redirect", redirect_pc, 32'h8000_0040);
        run_idle(1);
        chk("mret_mstatus", csr_mem[12'h300], 32'h0000_1888);

        // irq and request together: irq wins, request accepted after redirect
        t = idle_in(); t.irq = 1'b1; t.irq_pc = 32'h8000_0200;
        t.req_valid = 1'b1; t.req_type = 2'b00; t.req_pc = 32'h8000_0044;
        step(t);
        chk("irq_ack", 32'(irq_ack), 32'd1);
        chk("irq_req_blocked", 32'(req_ready), 32'd0);
        for (int k = 0; k < 5; k++) step(t);
        chk("irq_mcause", csr_mem[12'h342], 32'h8000_0007);
        chk("irq_mepc", csr_mem[12'h341], 32'h8000_0200);
        step(t);
        chk("held_req_accept", 32'(req_ready), 32'd1);
        run_idle(6);

        // mtvec low bits are masked in the redirect
        pass_wr(12'h305, 32'h8000_0303);
        t = idle_in(); t.req_valid = 1'b1; t.req_type = 2'b01; t.req_pc = 32'h8000_0050;
        step(t);
        run_idle(5);
        chk("ebreak_redirect", redirect_pc, 32'h8000_0300);
        chk("ebreak_mcause", csr_mem[12'h342], 32'd3);
        run_idle(1);

        // CSR-instruction write held across an ecall sequence
        t = idle_in(); t.req_valid = 1'b1; t.req_type = 2'b00; t.req_pc = 32'h8000_0060;
        t.inst_valid = 1'b1; t.inst_addr = 12'h340; t.inst_wdata = 32'h1234_5678;
        step(t);
        chk("inst_blocked_by_req", 32'(inst_csr_ready), 32'd0);
        t.req_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(t);
            chk("inst_blocked_busy", 32'(inst_csr_ready), 32'd0);
        end
        step(t);
        chk("inst_first_idle", 32'(inst_csr_ready), 32'd1);
        run_idle(1);
        chk("inst_written", csr_mem[12'h340], 32'h1234_5678);

        // Reset asserted in ST_RD: port goes quiet at once, sequence is dropped
        t = idle_in(); t.req_valid = 1'b1; t.req_type = 2'b00; t.req_pc = 32'h8000_0070;
        step(t);
        run_idle(3);
        chk("rst_pre_busy", 32'(busy), 32'd1);
        saved_st = csr_mem[12'h300];
        reset = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", 32'(csr_addr), 32'd0);
        chk("rst_wen", 32'(csr_wen), 32'd0);
        q.delete();
        m_mie = 1'b0;
        t = idle_in(); t.rst_n = 1'b0;
        step(t);
        run_idle(8);
        chk("rst_no_st_write", csr_mem[12'h300], saved_st);

        // Vector table: idle arbitration under each event mix
        for (int k = 0; k < 7; k++) begin
            pass_wr(12'h300, tbl[k].mie ? 32'h0000_1808 : 32'h0000_1800);
            t = idle_in();
            t.irq = tbl[k].irq; t.irq_pc = 32'h8000_1000 + 32'(k * 16);
            t.req_valid = tbl[k].req; t.req_type = tbl[k].typ;
            t.req_pc = 32'h8000_2000 + 32'(k * 16);
            t.inst_valid = tbl[k].inst; t.inst_addr = 12'h340; t.inst_wdata = 32'hA5A5_0000 + 32'(k);
            step(t);
            chk("tbl_irq_ack", 32'(irq_ack), 32'(tbl[k].e_ack));
            chk("tbl_req_ready", 32'(req_ready), 32'(tbl[k].e_rr));
            chk("tbl_inst_ready", 32'(inst_csr_ready), 32'(tbl[k].e_ir));
            run_idle(6);
            if (tbl[k].e_cause != 32'd0) chk("tbl_mcause", csr_mem[12'h342], tbl[k].e_cause);
        end

        // Randomized traffic against the reference model
        for (int k = 0; k < 500; k++) begin
            t = idle_in();
            t.rst_n      = ($urandom_range(0, 60) != 0);
            t.irq        = ($urandom_range(0, 3) == 0);
            t.irq_pc     = $urandom & ~32'h3;
            t.req_valid  = ($urandom_range(0, 2) == 0);
            t.req_type   = 2'($urandom_range(0, 3));
            t.req_pc     = $urandom & ~32'h3;
            t.inst_valid = ($urandom_range(0, 1) == 1);
            t.inst_addr  = addrs[$urandom_range(0, 4)];
            t.inst_wdata = $urandom;
            step(t);
        end
        run_idle(8);

        for (int k = 0; k < 5; k++) chk("csr_final", csr_mem[addrs[k]], ref_csr[addrs[k]]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ysyx_23060236_trap_ctrl.md
# ysyx_23060236_trap_ctrl

Trap sequencer that owns the single read/write port of the CSR file. It turns ecall, ebreak, illegal-instruction, mret and machine-interrupt events into ordered CSR read/write sequences (mepc, mcause, mstatus, mtvec) and emits one PC redirect per event. It arbitrates the port against ordinary CSR-instruction writes from the write-back stage. It sits between WBU/IFU and the CSR file.

## Interface
- No parameters; XLEN fixed at 32.
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  synchronous trap/return request from WBU
- req_ready  out  1  request accepted this cycle
- req_type  in  2  00 ecall, 01 ebreak, 10 illegal, 11 mret
- req_pc  in  32  PC of the requesting instruction
- irq  in  1  level machine-interrupt line
- irq_pc  in  32  PC of the next instruction to commit
- irq_ack  out  1  one-cycle pulse when an interrupt is taken
- inst_csr_valid  in  1  CSR-instruction write request
- inst_csr_addr  in  12  CSR address
- inst_csr_wdata  in  32  CSR write data
- inst_csr_ready  out  1  instruction write performed this cycle
- csr_addr  out  12  to CSR file imm
- csr_wdata  out  32  to CSR file wdata
- csr_wen  out  1  to CSR file enable and valid
- csr_rdata  in  32  from CSR file rdata
- redirect_valid  out  1  one-cycle redirect pulse
- redirect_pc  out  32  redirect target
- busy  out  1  state != IDLE

## Operation
- States: IDLE, EPC_WR, CAUSE_WR, ST_RD, ST_WR, VEC_RD, EPC_RD.
- IDLE priority, highest first:
  - irq && mie_shadow: take interrupt. Latch irq_pc and cause 0x80000007, pulse irq_ack, go to EPC_WR.
  - req_valid: req_ready=1. Latch req_pc and type. mret goes to ST_RD; others go to EPC_WR. Causes: ecall 11, ebreak 3, illegal 2.
  - inst_csr_valid: pass through to the CSR port with csr_wen=1 and inst_csr_ready=1. State stays IDLE.
- Exception/interrupt sequence:
  - EPC_WR: write 0x341 with the latched PC.
  - CAUSE_WR: write 0x342 with the latched cause.
  - ST_RD: read 0x300 and capture csr_rdata into st_q.
  - ST_WR: write 0x300 with st_q, modified as: MPIE[7] = MIE[3], MIE = 0, MPP[12:11] = 11.
  - VEC_RD: read 0x305. Drive redirect_pc = {csr_rdata[31:2], 2'b00} and redirect_valid=1, then go to IDLE.
- mret sequence:
  - ST_RD, then ST_WR with MIE = MPIE, MPIE = 1, MPP = 11.
  - EPC_RD: read 0x341. Drive redirect_pc = csr_rdata and redirect_valid=1, then go to IDLE.
- mie_shadow tracks mstatus.MIE:
  - Updated on every controller ST_WR.
  - Updated on a passthrough write to 0x300, taking bit 3 of the data.
- When csr_wen=0, csr_wdata is 0. When not IDLE, req_ready and inst_csr_ready are 0.

## Timing
- Reset (reset=0) is asynchronous and takes effect at any state. It forces state=IDLE, mie_shadow=0 and st_q=0, drops latched requests, and holds every output at 0.
- Exception latency: accept at cycle T, then EPC_WR at T+1, CAUSE_WR at T+2, ST_RD at T+3, ST_WR at T+4, VEC_RD with redirect at T+5. The next accept is possible at T+6.
- mret latency: accept at T, ST_RD at T+1, ST_WR at T+2, EPC_RD with redirect at T+3.
- Passthrough writes take 0 added cycles; the CSR file updates at the next edge.
- Simultaneous events in IDLE:
  - irq beats req. The request stays pending, because req_ready=0, and WBU must hold it.
  - req beats inst_csr.
- irq arriving while busy is ignored until IDLE. It is still observed then only if it is still high and mie_shadow=1.
- irq with mie_shadow=0 never fires.

## Structure
- Shared package holds:
  - CSR addresses: 0x341, 0x342, 0x300, 0x305.
  - Cause codes and req_type encodings.
  - State enum, binary-encoded in 3 bits.
- One sub-module, ysyx_23060236_mstatus_upd: purely combinational, (st_in, is_mret) → st_out, implementing both field rewrites.
- FSM, arbitration and latches live in the top.

## Test plan
- Reset with mtvec=0x80000100 and mstatus=0x1808, then an ecall with req_pc=0x80000040 → writes in order: mepc=0x80000040, mcause=11, mstatus=0x1880; redirect_pc=0x80000100 at T+5.
- mret after that ecall (mepc=0x80000040, mstatus=0x1880) → mstatus=0x1888, redirect_pc=0x80000040 at T+3, mie_shadow=1.
- irq=1 and req_valid=1 in the same IDLE cycle with MIE=1 and irq_pc=0x80000200 → irq_ack=1, req_ready=0, mcause=0x80000007, mepc=0x80000200. The request is accepted after the redirect.
- inst_csr write of 0x305←0x80000303, then ebreak → redirect_pc=0x80000300 and mcause=3.
- inst_csr_valid held during an ecall sequence → inst_csr_ready=0 for 5 cycles; the write is performed in the first IDLE cycle.
- reset driven low at ST_RD → all outputs 0 immediately, busy=0. After release, no redirect and no further CSR writes occur.
